// File: rtl/sched_seq_pkg.sv
// Shared definitions for the iteration scheduler: FSM state encoding,
// toggle-bit index helpers and default geometry.
package sched_seq_pkg;

  localparam int DEFAULT_NUM_BUFFS  = 12;
  localparam int DEFAULT_CTRL_DEPTH = 48;
  localparam int DEFAULT_ITER_W     = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } sched_state_e;

  // Row bit carrying the write toggle of buffer i.
  function automatic int wr_bit(input int i);
    return 2 * i;
  endfunction

  // Row bit carrying the read toggle of buffer i.
  function automatic int rd_bit(input int i);
    return (2 * i) + 1;
  endfunction

endpackage

// File: rtl/sched_seq_if.sv
// Control/status bundle between the scheduler and its host and the
// buffer controllers. master = host side, slave = scheduler side.
interface sched_seq_if
  import sched_seq_pkg::*;
#(
  parameter int NUM_BUFFS  = DEFAULT_NUM_BUFFS,
  parameter int CTRL_DEPTH = DEFAULT_CTRL_DEPTH
);
  localparam int CTRL_WIDTH = NUM_BUFFS * 2;
  localparam int SLOT_W     = $clog2(CTRL_DEPTH);

  logic                  load_ctrl;
  logic [CTRL_WIDTH-1:0] ctrl_in;
  logic                  start_ctrl;
  logic                  stop_ctrl;
  logic                  buff_wr_toggle [NUM_BUFFS];
  logic                  buff_rd_toggle [NUM_BUFFS];
  logic [SLOT_W-1:0]     slot_idx;
  logic                  running;
  logic                  load_done;
  logic                  load_err;
  logic                  start_err;

  modport master (
    output load_ctrl, ctrl_in, start_ctrl, stop_ctrl,
    input  buff_wr_toggle, buff_rd_toggle, slot_idx, running,
           load_done, load_err, start_err
  );

  modport slave (
    input  load_ctrl, ctrl_in, start_ctrl, stop_ctrl,
    output buff_wr_toggle, buff_rd_toggle, slot_idx, running,
           load_done, load_err, start_err
  );

endinterface

// File: rtl/sched_seq_table_bank.sv
// Double-banked schedule table. One bank is active (read by playback),
// the other is the shadow (written by the loader). A swap flips roles.
module sched_table_bank
  import sched_seq_pkg::*;
#(
  parameter int CTRL_WIDTH = DEFAULT_NUM_BUFFS * 2,
  parameter int CTRL_DEPTH = DEFAULT_CTRL_DEPTH,
  parameter int SLOT_W     = $clog2(CTRL_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [SLOT_W-1:0]     wr_addr,
  input  logic [CTRL_WIDTH-1:0] wr_data,
  input  logic                  swap,
  input  logic [SLOT_W-1:0]     rd_addr,
  output logic [CTRL_WIDTH-1:0] rd_data
);

  logic [CTRL_WIDTH-1:0] bank0_r [CTRL_DEPTH];
  logic [CTRL_WIDTH-1:0] bank1_r [CTRL_DEPTH];
  logic                  bank_sel_r;  // index of the active bank

  // Active-bank selector; flips on every swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_sel_r <= 1'b0;
    end else if (swap) begin
      bank_sel_r <= ~bank_sel_r;
    end else begin
      bank_sel_r <= bank_sel_r;
    end
  end

  // Row storage: writes always land in the bank that is not active.
  // Contents carry no reset; validity is tracked by the sequencer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (bank_sel_r) begin
        bank0_r[wr_addr] <= wr_data;
      end else begin
        bank1_r[wr_addr] <= wr_data;
      end
    end
  end

  // Combinational read of the active bank for the current slot.
  always_comb begin
    rd_data = {CTRL_WIDTH{1'b0}};
    if (bank_sel_r) begin
      rd_data = bank1_r[rd_addr];
    end else begin
      rd_data = bank0_r[rd_addr];
    end
  end

endmodule

// File: rtl/sched_seq.sv
// Iteration scheduler: loads a per-slot toggle table into a shadow bank,
// swaps it in at iteration boundaries and replays the active table
// cyclically, driving per-buffer write/read ping-pong levels.
// Optional: define SCHED_SEQ_ITER_CNT_EN to add the iter_cnt output
// (count of completed iterations).
module sched_seq
  import sched_seq_pkg::*;
#(
  parameter int NUM_BUFFS  = DEFAULT_NUM_BUFFS,
  parameter int CTRL_WIDTH = NUM_BUFFS * 2,
  parameter int CTRL_DEPTH = DEFAULT_CTRL_DEPTH,
  parameter int ITER_W     = DEFAULT_ITER_W
) (
  input  logic              clk,
  input  logic              rst,
  sched_seq_if.slave        bus
`ifdef SCHED_SEQ_ITER_CNT_EN
  ,
  output logic [ITER_W-1:0] iter_cnt
`endif
);

  localparam int                SLOT_W    = $clog2(CTRL_DEPTH);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CTRL_DEPTH - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1'b1);
  localparam logic [SLOT_W-1:0] SLOT_ZERO = SLOT_W'(1'b0);

  sched_state_e          state_r;
  sched_state_e          state_s;
  logic [SLOT_W-1:0]     slot_r;
  logic [SLOT_W-1:0]     ld_ptr_r;
  logic                  active_valid_r;
  logic                  shadow_full_r;
  logic [NUM_BUFFS-1:0]  wr_tog_r;
  logic [NUM_BUFFS-1:0]  rd_tog_r;
  logic                  running_r;
  logic                  load_done_r;
  logic                  load_err_r;
  logic                  start_err_r;

  logic [CTRL_WIDTH-1:0] active_row_s;
  logic [NUM_BUFFS-1:0]  wr_row_s;
  logic [NUM_BUFFS-1:0]  rd_row_s;
  logic                  play_s;
  logic                  last_slot_s;
  logic                  shadow_we_s;
  logic                  load_drop_s;
  logic                  last_row_s;
  logic                  swap_s;
  logic                  start_ok_s;
  logic                  start_rej_s;

  sched_table_bank #(
    .CTRL_WIDTH (CTRL_WIDTH),
    .CTRL_DEPTH (CTRL_DEPTH),
    .SLOT_W     (SLOT_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (shadow_we_s),
    .wr_addr (ld_ptr_r),
    .wr_data (bus.ctrl_in),
    .swap    (swap_s),
    .rd_addr (slot_r),
    .rd_data (active_row_s)
  );

  // Control decode shared by the FSM, loader and playback.
  always_comb begin
    play_s      = (state_r == RUN) || (state_r == STOPPING);
    last_slot_s = (slot_r == LAST_SLOT);
    shadow_we_s = bus.load_ctrl && !shadow_full_r;
    load_drop_s = bus.load_ctrl && shadow_full_r;
    last_row_s  = shadow_we_s && (ld_ptr_r == LAST_SLOT);
    // Swap only at an iteration boundary so no iteration mixes tables.
    swap_s      = shadow_full_r && ((state_r == IDLE) || (play_s && last_slot_s));
    // In IDLE a simultaneous stop overrides start.
    start_ok_s  = (state_r == IDLE) && bus.start_ctrl && !bus.stop_ctrl && active_valid_r;
    start_rej_s = (state_r == IDLE) && bus.start_ctrl && !bus.stop_ctrl && !active_valid_r;
  end

  // Split the active row into per-buffer write and read toggle masks.
  always_comb begin
    wr_row_s = {NUM_BUFFS{1'b0}};
    rd_row_s = {NUM_BUFFS{1'b0}};
    for (int i = 0; i < NUM_BUFFS; i++) begin
      wr_row_s[i] = active_row_s[wr_bit(i)];
      rd_row_s[i] = active_row_s[rd_bit(i)];
    end
  end

  // Next-state logic for IDLE / RUN / STOPPING.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (bus.stop_ctrl) begin
          state_s = STOPPING;
        end else begin
          state_s = RUN;
        end
      end
      STOPPING: begin
        if (bus.start_ctrl) begin
          state_s = RUN;
        end else if (last_slot_s) begin
          state_s = IDLE;
        end else begin
          state_s = STOPPING;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register plus registered status and one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      running_r   <= 1'b0;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
      start_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      running_r   <= (state_s != IDLE);
      load_done_r <= last_row_s;
      load_err_r  <= load_drop_s;
      start_err_r <= start_rej_s;
    end
  end

  // Shadow loader pointer and bank validity flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_ptr_r       <= SLOT_ZERO;
      shadow_full_r  <= 1'b0;
      active_valid_r <= 1'b0;
    end else begin
      if (last_row_s) begin
        ld_ptr_r <= SLOT_ZERO;
      end else if (shadow_we_s) begin
        ld_ptr_r <= ld_ptr_r + SLOT_ONE;
      end else begin
        ld_ptr_r <= ld_ptr_r;
      end
      if (swap_s) begin
        shadow_full_r  <= 1'b0;
        active_valid_r <= 1'b1;
      end else if (last_row_s) begin
        shadow_full_r  <= 1'b1;
        active_valid_r <= active_valid_r;
      end else begin
        shadow_full_r  <= shadow_full_r;
        active_valid_r <= active_valid_r;
      end
    end
  end

  // Playback: apply the current slot's toggles and advance the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_r   <= SLOT_ZERO;
      wr_tog_r <= {NUM_BUFFS{1'b0}};
      rd_tog_r <= {NUM_BUFFS{1'b0}};
    end else if (start_ok_s) begin
      slot_r   <= SLOT_ZERO;
      wr_tog_r <= wr_tog_r;
      rd_tog_r <= rd_tog_r;
    end else if (play_s) begin
      slot_r   <= last_slot_s ? SLOT_ZERO : (slot_r + SLOT_ONE);
      wr_tog_r <= wr_tog_r ^ wr_row_s;
      rd_tog_r <= rd_tog_r ^ rd_row_s;
    end else begin
      slot_r   <= slot_r;
      wr_tog_r <= wr_tog_r;
      rd_tog_r <= rd_tog_r;
    end
  end

`ifdef SCHED_SEQ_ITER_CNT_EN
  logic [ITER_W-1:0] iter_cnt_r;

  // Completed-iteration counter; cleared on start, bumped on slot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_cnt_r <= {ITER_W{1'b0}};
    end else if (start_ok_s) begin
      iter_cnt_r <= {ITER_W{1'b0}};
    end else if (play_s && last_slot_s) begin
      iter_cnt_r <= iter_cnt_r + ITER_W'(1'b1);
    end else begin
      iter_cnt_r <= iter_cnt_r;
    end
  end

  assign iter_cnt = iter_cnt_r;
`endif

  // Drive the unpacked toggle outputs from the toggle registers.
  always_comb begin
    for (int i = 0; i < NUM_BUFFS; i++) begin
      bus.buff_wr_toggle[i] = wr_tog_r[i];
      bus.buff_rd_toggle[i] = rd_tog_r[i];
    end
  end

  assign bus.slot_idx  = slot_r;
  assign bus.running   = running_r;
  assign bus.load_done = load_done_r;
  assign bus.load_err  = load_err_r;
  assign bus.start_err = start_err_r;

endmodule
